// File: rtl/coreinfo_pkg.sv
// coreinfo_pkg: shared constants, types and helpers for the
// ZX-UNO text-identification register block.
package coreinfo_pkg;

  // Well-known ZX-UNO register addresses for text channels.
  localparam logic [7:0] ADDR_COREID    = 8'hFF;
  localparam logic [7:0] ADDR_BUILDINFO = 8'hFE;

  // Per-channel control bundle produced by the top-level decode.
  typedef struct packed {
    logic rewind;
    logic seek;
    logic regwr;
    logic rd;
  } chan_ctl_t;

  // Ceiling log2, used to size the byte index.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/coreinfo_chan.sv
// coreinfo_chan: one text channel -- byte index, read/write
// access tracking and the channel's ROM slice.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   ctl        : decoded rewind/seek/regwr/read for this channel
//   din        : write data; low IW bits are the seek target
//   rdata      : ROM byte at the current index (combinational)
module coreinfo_chan
  import coreinfo_pkg::*;
#(
  parameter int                     MAX_LEN     = 16,
  parameter int                     STOP_AT_NUL = 0,
  parameter logic [MAX_LEN*8-1:0]   CH_TEXT     = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  chan_ctl_t ctl,
  input  logic [7:0] din,
  output logic [7:0] rdata
);

  localparam int IW = clog2(MAX_LEN);

  logic [IW-1:0] idx_q, idx_d;
  logic          rd_act_q, rd_act_d;
  logic          wr_act_q, wr_act_d;

  logic [7:0] cur;
  logic       last;
  logic       hold;
  logic       unused_din_hi;

  assign cur   = CH_TEXT[{idx_q, 3'b000} +: 8];
  assign rdata = cur;
  assign last  = (idx_q == IW'(MAX_LEN - 1));

  // In stop mode the index parks on a NUL or the last byte.
  assign hold = (STOP_AT_NUL != 0) && ((cur == 8'h00) || last);

  assign unused_din_hi = ^din[7:IW];

  always_comb begin
    idx_d    = idx_q;
    rd_act_d = rd_act_q;
    wr_act_d = wr_act_q;
    unique case (1'b1)
      ctl.rewind: begin
        idx_d    = '0;
        rd_act_d = 1'b0;
        wr_act_d = 1'b0;
      end
      (ctl.seek && !wr_act_q): begin
        // Seek also discards any read
        // that ends on the same cycle.
        idx_d    = din[IW-1:0];
        wr_act_d = 1'b1;
        rd_act_d = 1'b0;
      end
      default: begin
        if (!ctl.regwr) wr_act_d = 1'b0;
        if (ctl.rd) begin
          rd_act_d = 1'b1;
        end else if (rd_act_q) begin
          // Advance once, after the access.
          rd_act_d = 1'b0;
          if (!hold) idx_d = idx_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      rd_act_q <= 1'b0;
      wr_act_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      rd_act_q <= rd_act_d;
      wr_act_q <= wr_act_d;
    end
  end

endmodule

// File: rtl/coreinfo_regs.sv
// coreinfo_regs: multi-channel read-only text ID registers
// on the ZX-UNO register bus, one byte streamed per read.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   zxuno_addr      : selected register address
//   zxuno_regrd     : read strobe, high for whole access
//   zxuno_regwr     : write strobe, high for whole access
//   regaddr_changed : pulse when zxuno_addr is written
//   din             : write data (seek target)
//   dout            : registered byte of selected channel
//   oe_n            : active-low read enable to bus mux
module coreinfo_regs
  import coreinfo_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter logic [7:0] BASE_ADDR   = 8'hFE,
  parameter int         MAX_LEN     = 16,
  parameter logic [NUM_CH*MAX_LEN*8-1:0] TEXT = '0,
  parameter int         STOP_AT_NUL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic       regaddr_changed,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n
);

  logic [8:0] off;
  logic [7:0] sel;
  logic       hit;

  // 9-bit difference: bit 8 flags addresses below the base.
  assign off = {1'b0, zxuno_addr} - {1'b0, BASE_ADDR};
  assign sel = off[7:0];
  assign hit = !off[8] && (sel < 8'(NUM_CH));

  assign oe_n = !(hit && zxuno_regrd);

  chan_ctl_t  ctl       [NUM_CH];
  logic [7:0] chan_byte [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic me;
    assign me = hit && (sel == 8'(g));

    assign ctl[g] = '{
      rewind: regaddr_changed && me,
      seek:   zxuno_regwr && me,
      regwr:  zxuno_regwr,
      rd:     !oe_n && me
    };

    coreinfo_chan #(
      .MAX_LEN    (MAX_LEN),
      .STOP_AT_NUL(STOP_AT_NUL),
      .CH_TEXT    (TEXT[g*MAX_LEN*8 +: MAX_LEN*8])
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .ctl  (ctl[g]),
      .din  (din),
      .rdata(chan_byte[g])
    );
  end

  logic [7:0] dout_d, dout_q;

  always_comb begin
    dout_d = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit && (sel == 8'(c))) dout_d = chan_byte[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dout_q <= 8'h00;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_coreinfo_regs.sv
// tb_coreinfo_regs: three configurations on a shared bus,
// checked against an access-level string model.
module tb_coreinfo_regs;

  localparam logic [255:0] TXT_A = {104'h0, "ZYX", 112'h0, "BA"};
  localparam logic [63:0]  TXT_B = {"WZYX", 16'h0, "BA"};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic       regaddr_changed = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout_v [3];
  logic       oe_v   [3];

  always #5 clk = ~clk;

  coreinfo_regs #(
    .NUM_CH(2), .BASE_ADDR(8'hFE), .MAX_LEN(16),
    .TEXT(TXT_A), .STOP_AT_NUL(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .regaddr_changed(regaddr_changed), .din(din),
    .dout(dout_v[0]), .oe_n(oe_v[0])
  );

  coreinfo_regs #(
    .NUM_CH(2), .BASE_ADDR(8'hFE), .MAX_LEN(4),
    .TEXT(TXT_B), .STOP_AT_NUL(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .regaddr_changed(regaddr_changed), .din(din),
    .dout(dout_v[1]), .oe_n(oe_v[1])
  );

  coreinfo_regs #(
    .NUM_CH(2), .BASE_ADDR(8'hFE), .MAX_LEN(16),
    .TEXT(TXT_A), .STOP_AT_NUL(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .regaddr_changed(regaddr_changed), .din(din),
    .dout(dout_v[2]), .oe_n(oe_v[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current byte position per instance/channel.
  int idx_m [3][2];
  int ml    [3] = '{16, 4, 16};
  int stp   [3] = '{0, 0, 1};

  logic [7:0] got_v [3];
  logic       oe_rd [3];
  logic       oe_af [3];

  function automatic logic [7:0] ref_byte(int k, int ch, int i);
    if (k == 1) return TXT_B[(ch*4 + i)*8 +: 8];
    return TXT_A[(ch*16 + i)*8 +: 8];
  endfunction

  function automatic logic [7:0] m_exp(int k, int ch);
    return ref_byte(k, ch, idx_m[k][ch]);
  endfunction

  task automatic m_adv(int k, int ch);
    int i;
    i = idx_m[k][ch];
    if (stp[k] != 0) begin
      if (ref_byte(k, ch, i) != 8'h00 && i != ml[k] - 1)
        idx_m[k][ch] = i + 1;
    end else begin
      idx_m[k][ch] = (i + 1) % ml[k];
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++) idx_m[k][c] = 0;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full read access: sample mid-access, then let it end.
  task automatic bus_read(logic [7:0] a);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      got_v[k] = dout_v[k];
      oe_rd[k] = oe_v[k];
    end
    zxuno_regrd = 1'b0;
    tick(1);
    for (int k = 0; k < 3; k++) oe_af[k] = oe_v[k];
    tick(1);
  endtask

  task automatic bus_write(logic [7:0] a, logic [7:0] d, int n);
    zxuno_addr  = a;
    din         = d;
    zxuno_regwr = 1'b1;
    tick(n);
    zxuno_regwr = 1'b0;
    tick(1);
  endtask

  task automatic bus_rewind(logic [7:0] a);
    zxuno_addr      = a;
    regaddr_changed = 1'b1;
    tick(1);
    regaddr_changed = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    zxuno_addr = 8'hFF;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dout_v[k] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout inst%0d got %02h want 00", k, dout_v[k]);
      end
      n_tests++;
      if (oe_v[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_oe inst%0d got %b want 1", k, oe_v[k]);
      end
    end
    rst_n = 1'b1;
    m_reset();
    tick(2);
  endtask

  task automatic read_check(string nm, int ch);
    bus_read(8'hFE + 8'(ch));
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_v[k] !== m_exp(k, ch)) begin
        n_fail++;
        $display("FAIL %s inst%0d ch%0d got %02h want %02h",
                 nm, k, ch, got_v[k], m_exp(k, ch));
      end
      m_adv(k, ch);
      n_tests++;
      if (oe_rd[k] !== 1'b0 || oe_af[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_oe inst%0d got %b/%b want 0/1",
                 nm, k, oe_rd[k], oe_af[k]);
      end
    end
  endtask

  task automatic test_basic_read();
    for (int r = 0; r < 4; r++) read_check("basic_read", 1);
  endtask

  task automatic test_wrap();
    bus_rewind(8'hFF);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 0;
    for (int r = 0; r < 5; r++) read_check("wrap", 1);
  endtask

  task automatic test_stop();
    bus_rewind(8'hFE);
    for (int k = 0; k < 3; k++) idx_m[k][0] = 0;
    for (int r = 0; r < 5; r++) read_check("stop_nul", 0);
  endtask

  task automatic test_rewind();
    bus_rewind(8'hFF);
    bus_rewind(8'hFE);
    m_reset();
    read_check("rw_ch1", 1);
    read_check("rw_ch1", 1);
    read_check("rw_ch0", 0);
    bus_rewind(8'hFF);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 0;
    read_check("rw_after", 1);
    read_check("rw_other", 0);
  endtask

  task automatic test_seek();
    bus_write(8'hFF, 8'h02, 3);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 2 % ml[k];
    read_check("seek_02", 1);
    bus_write(8'hFF, 8'h13, 2);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 8'h13 % ml[k];
    read_check("seek_13", 1);
  endtask

  // Seek or rewind landing on the read-end cycle.
  task automatic test_collide();
    bus_rewind(8'hFF);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 0;
    zxuno_addr  = 8'hFF;
    zxuno_regrd = 1'b1;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dout_v[k] !== m_exp(k, 1)) begin
        n_fail++;
        $display("FAIL collide_seek_rd inst%0d got %02h want %02h",
                 k, dout_v[k], m_exp(k, 1));
      end
    end
    zxuno_regrd = 1'b0;
    zxuno_regwr = 1'b1;
    din = 8'h05;
    tick(1);
    zxuno_regwr = 1'b0;
    tick(1);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 5 % ml[k];
    read_check("seek_beats_end", 1);
    zxuno_regrd = 1'b1;
    tick(2);
    zxuno_regrd = 1'b0;
    regaddr_changed = 1'b1;
    tick(1);
    regaddr_changed = 1'b0;
    tick(1);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 0;
    read_check("rewind_beats_end", 1);
  endtask

  task automatic test_no_hit();
    logic [7:0] a [2];
    a[0] = 8'h10;
    a[1] = 8'hFD;
    for (int j = 0; j < 2; j++) begin
      bus_read(a[j]);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (got_v[k] !== 8'h00 || oe_rd[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL no_hit inst%0d addr %02h got %02h/%b want 00/1",
                   k, a[j], got_v[k], oe_rd[k]);
        end
      end
    end
    read_check("after_no_hit", 1);
  endtask

  task automatic test_reset_mid_read();
    bus_rewind(8'hFF);
    for (int k = 0; k < 3; k++) idx_m[k][1] = 0;
    read_check("mid_pre", 1);
    read_check("mid_pre", 1);
    zxuno_addr  = 8'hFF;
    zxuno_regrd = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dout_v[k] !== 8'h00 || oe_v[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset inst%0d got %02h/%b want 00/0",
                 k, dout_v[k], oe_v[k]);
      end
    end
    zxuno_regrd = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_reset();
    tick(2);
    read_check("post_reset", 1);
  endtask

  task automatic test_random();
    int op, ch, n;
    logic [7:0] d;
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, 1);
      if (op <= 5) begin
        read_check("rand_read", ch);
      end else if (op <= 7) begin
        d = 8'($urandom);
        n = $urandom_range(1, 3);
        bus_write(8'hFE + 8'(ch), d, n);
        for (int k = 0; k < 3; k++) idx_m[k][ch] = int'(d) % ml[k];
      end else if (op == 8) begin
        bus_rewind(8'hFE + 8'(ch));
        for (int k = 0; k < 3; k++) idx_m[k][ch] = 0;
      end else begin
        d = 8'($urandom_range(0, 8'hFD));
        bus_read(d);
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (got_v[k] !== 8'h00) begin
            n_fail++;
            $display("FAIL rand_no_hit inst%0d got %02h want 00",
                     k, got_v[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_wrap();
    test_stop();
    test_rewind();
    test_seek();
    test_collide();
    test_no_hit();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
